// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multicycle RISC-V control FSM driving ALU control, datapath selects and enables
//
// Purpose:
//   Sequences FETCH -> DECODE -> execute -> writeback for lw, sw, R-type,
//   I-type ALU, beq and jal. Produces the ALU operation encoding and every
//   datapath select and write enable for the multicycle core.
//
// Parameters:
//   ENABLE_MUL  1: R-type funct7=0000001/funct3=000 is MUL; 0: it is illegal
//   STATE_W     width of the state register and the state debug port (>= 4)
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op, funct3,
//   funct7b5, funct7b0    instruction fields held in the instruction register
//   zero                  ALU zero flag, used to resolve beq
//   PCWrite, AdrSrc,
//   MemWrite, IRWrite,
//   RegWrite              datapath enables / memory address select
//   ResultSrc, ALUSrcA,
//   ALUSrcB, ImmSrc       datapath multiplexer selects
//   ALUControl            ALU operation
//   illegal               one-cycle pulse in DECODE on an unsupported instruction
//   retire                one-cycle pulse in the last state of a legal instruction
//   state                 current state, debug only

module alu_ctrl_fsm #(
    parameter int ENABLE_MUL = 1,
    parameter int STATE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               funct7b0,
    input  logic               zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               illegal,
    output logic               retire,
    output logic [STATE_W-1:0] state
);

    localparam logic MUL_EN = (ENABLE_MUL != 0);

    // State encoding; codes 11..(2^STATE_W-1) are unused and recover to FETCH.
    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // Moore outputs before reset gating
    logic       pc_update_m;
    logic       branch_m;
    logic       adr_src_m;
    logic       mem_write_m;
    logic       ir_write_m;
    logic       reg_write_m;
    logic       retire_m;
    logic       illegal_m;
    logic [1:0] result_src_m;
    logic [1:0] alu_src_a_m;
    logic [1:0] alu_src_b_m;
    logic [1:0] alu_op_m;

    logic       funct3_ok;
    logic       legal;
    logic [1:0] imm_src_dec;
    logic [2:0] alu_ctrl_dec;

    // ------------------------------------------------------------------
    // Instruction legality, evaluated while the IR holds the new instruction
    // ------------------------------------------------------------------
    assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b110) || (funct3 == 3'b111);

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_JAL: legal = 1'b1;
            OP_BEQ:               legal = (funct3 == 3'b000);
            // slli is the only I-type whose funct7 matters; it must be zero
            OP_I:                 legal = funct3_ok &&
                                          ((funct3 != 3'b001) || !(funct7b5 || funct7b0));
            // Non-zero funct7 is only meaningful for funct3=000 (sub or mul),
            // and the two bits are mutually exclusive.
            OP_R:                 legal = funct3_ok &&
                                          ((!funct7b5 && !funct7b0) ||
                                           ((funct3 == 3'b000) && (funct7b5 ^ funct7b0) &&
                                            (funct7b5 || MUL_EN)));
            default:              legal = 1'b0;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        imm_src_dec = 2'b00;
        case (op)
            OP_SW:   imm_src_dec = 2'b01;
            OP_BEQ:  imm_src_dec = 2'b10;
            OP_JAL:  imm_src_dec = 2'b11;
            default: imm_src_dec = 2'b00;
        endcase
    end

    // ALU decoder; op[5] separates R-type from I-type so I-type never gets sub/mul
    always_comb begin
        alu_ctrl_dec = ALU_ADD;
        case (alu_op_m)
            2'b00: alu_ctrl_dec = ALU_ADD;
            2'b01: alu_ctrl_dec = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (op[5] && funct7b5)
                            alu_ctrl_dec = ALU_SUB;
                        else if (op[5] && funct7b0 && MUL_EN)
                            alu_ctrl_dec = ALU_MUL;
                        else
                            alu_ctrl_dec = ALU_ADD;
                    end
                    3'b001:  alu_ctrl_dec = ALU_SLL;
                    3'b010:  alu_ctrl_dec = ALU_SLT;
                    3'b110:  alu_ctrl_dec = ALU_OR;
                    3'b111:  alu_ctrl_dec = ALU_AND;
                    default: alu_ctrl_dec = ALU_ADD;
                endcase
            end
            default: alu_ctrl_dec = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECR;
                        OP_I:         state_d = S_EXECI;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output logic
    // ------------------------------------------------------------------
    always_comb begin
        pc_update_m  = 1'b0;
        branch_m     = 1'b0;
        adr_src_m    = 1'b0;
        mem_write_m  = 1'b0;
        ir_write_m   = 1'b0;
        reg_write_m  = 1'b0;
        retire_m     = 1'b0;
        illegal_m    = 1'b0;
        result_src_m = 2'b00;
        alu_src_a_m  = 2'b00;
        alu_src_b_m  = 2'b00;
        alu_op_m     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_m   = 1'b1;
                pc_update_m  = 1'b1;
                alu_src_b_m  = 2'b10;
                result_src_m = 2'b10;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQ only has to compare
                alu_src_a_m = 2'b01;
                alu_src_b_m = 2'b01;
                illegal_m   = !legal;
            end
            S_MEMADR: begin
                alu_src_a_m = 2'b10;
                alu_src_b_m = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_m = 1'b1;
            end
            S_MEMWB: begin
                result_src_m = 2'b01;
                reg_write_m  = 1'b1;
                retire_m     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_m   = 1'b1;
                mem_write_m = 1'b1;
                retire_m    = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_m = 2'b10;
                alu_op_m    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_m = 2'b10;
                alu_src_b_m = 2'b01;
                alu_op_m    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_m = 1'b1;
                retire_m    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_m = 2'b10;
                alu_op_m    = 2'b01;
                branch_m    = 1'b1;
                retire_m    = 1'b1;
            end
            S_JAL: begin
                alu_src_a_m = 2'b01;
                alu_src_b_m = 2'b10;
                pc_update_m = 1'b1;
            end
            default: begin
                // Unused encodings drive nothing and fall back to FETCH
            end
        endcase
    end

    // Reset overrides every output so an abandoned instruction writes nothing
    assign PCWrite    = rst_n && (pc_update_m || (branch_m && zero));
    assign AdrSrc     = rst_n && adr_src_m;
    assign MemWrite   = rst_n && mem_write_m;
    assign IRWrite    = rst_n && ir_write_m;
    assign RegWrite   = rst_n && reg_write_m;
    assign illegal    = rst_n && illegal_m;
    assign retire     = rst_n && retire_m;
    assign ResultSrc  = rst_n ? result_src_m : 2'b00;
    assign ALUSrcA    = rst_n ? alu_src_a_m  : 2'b00;
    assign ALUSrcB    = rst_n ? alu_src_b_m  : 2'b00;
    assign ImmSrc     = rst_n ? imm_src_dec  : 2'b00;
    assign ALUControl = rst_n ? alu_ctrl_dec : 3'b000;
    assign state      = state_q;

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multicycle control unit that drives the ALU's `ALUControl[2:0]` plus all datapath selects and write-enables for the RISC-V multicycle core.
- It decodes opcode/funct fields held in the instruction register and sequences Fetch → Decode → Execute → Writeback.
- It consumes the ALU `zero` flag to resolve BEQ.
- It is the producer side of the ALU control interface; the ALU encoding below is binding.

Parameters:
- ENABLE_MUL, 1: 1 = R-type funct7=0000001/funct3=000 decodes as MUL (`ALUControl`=100); 0 = that encoding is illegal.
- STATE_W, 4: width of the state register and of the `state` debug port.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- funct7b0  in  1  instr[25]
- zero  in  1  ALU zero flag, same-cycle combinational
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = mem data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 (A)
- ALUSrcB  out  2  00 = rs2 (B), 01 = imm, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 mul, 101 sll, 110 slt
- illegal  out  1  one-cycle pulse in Decode on an unsupported instruction
- retire  out  1  one-cycle pulse in the last state of each legal instruction
- state  out  STATE_W  current state, debug only

Behaviour:
- Reset: on a clk edge with rst_n=0, state ← FETCH. While rst_n=0, PCWrite, MemWrite, IRWrite, RegWrite, illegal and retire are forced to 0 combinationally; all selects read 0. Reset mid-instruction abandons it, and no enable fires in that cycle.
- Outputs are Moore (from state) except:
  - PCWrite = PCUpdate | (Branch & zero)
  - ImmSrc is decoded from op
  - ALUControl is decoded from ALUOp/funct
- ALUOp 00 → add. ALUOp 01 → sub.
- ALUOp 10 decodes funct3:
  - 000 → sub if op[5] & funct7b5; mul if op[5] & funct7b0 & ENABLE_MUL; else add
  - 001 → sll
  - 010 → slt
  - 110 → or
  - 111 → and
  - others → illegal
- Legal ops:
  - lw 0000011
  - sw 0100011
  - R 0110011
  - I-ALU 0010011
  - beq 1100011 with funct3=000
  - jal 1101111
- FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, add, ResultSrc=10, PCUpdate. Next: DECODE.
- DECODE: A=OldPC, B=imm, add (branch target into ALUOut). Next:
  - lw/sw → MEMADR
  - R → EXECR
  - I → EXECI
  - beq → BEQ
  - jal → JAL
  - illegal → FETCH, with illegal=1 and no enables
- MEMADR: A=rs1, B=imm, add. Next: lw → MEMREAD, sw → MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, retire. Next: FETCH.
- EXECR: A=rs1, B=rs2, ALUOp=10. Next: ALUWB.
- EXECI: A=rs1, B=imm, ALUOp=10. Next: ALUWB.
  - I-type never selects sub or mul: funct7 is ignored except for slli, and slli with funct7≠0 is illegal.
- ALUWB: ResultSrc=00, RegWrite=1, retire. Next: FETCH.
- BEQ: A=rs1, B=rs2, sub, ResultSrc=00, Branch, retire. Next: FETCH.
- JAL: A=OldPC, B=4, add, ResultSrc=00, PCUpdate. Next: ALUWB (rd ← PC+4).
- Cycle counts:
  - lw 5
  - sw 4
  - R 4
  - I 4
  - beq 3
  - jal 4
  - illegal 2
- Undefined state encodings → FETCH next cycle, with all enables 0 in the bad state.
- Exactly one of the following per cycle, at most: IRWrite, MemWrite, RegWrite.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-EXECR → state=FETCH after edge; RegWrite never asserted; first post-reset cycle has IRWrite=1, PCWrite=1, ALUControl=000.
- R-type sweep:
  - add (f3=000, f7=0) → EXECR ALUControl=000
  - sub (f7b5=1) → 001
  - and → 010
  - or → 011
  - slt → 110
  - sll → 101
  - mul (f7b0=1) → 100
  - each: 4 cycles, RegWrite only in ALUWB, retire once
  - repeat with ENABLE_MUL=0 → mul raises illegal
- lw then sw:
  - lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, with ImmSrc=00 and AdrSrc=1 in MEMREAD
  - sw: MEMWRITE has MemWrite=1, ImmSrc=01, 4 cycles total
- beq: zero=1 in BEQ → PCWrite=1, ALUControl=001; zero=0 → PCWrite=0; both 3 cycles, ImmSrc=10.
- jal: states JAL→ALUWB; PCWrite=1 in JAL, RegWrite=1 in ALUWB, ImmSrc=11.
- Illegal: op=0000000, and beq with funct3=001 → illegal pulse in DECODE, return to FETCH, no MemWrite/RegWrite, retire=0.
